// File: rtl/key_dispatcher_if.sv
// Handshake bundle between the key dispatcher, the LFSR key generator and the
// decryption cores. master = dispatcher side, slave = generator/cores side.
interface key_dispatcher_if #(
   parameter int NUM_CORES = 4,
   parameter int KEY_WIDTH = 24
);
   logic                           lfsr_reset;
   logic [KEY_WIDTH-1:0]           key_in;
   logic                           key_available;
   logic                           key_exhausted;
   logic                           key_read;
   logic [NUM_CORES-1:0]           core_req;
   logic [NUM_CORES-1:0]           core_busy;
   logic [NUM_CORES-1:0]           core_found;
   logic [NUM_CORES*KEY_WIDTH-1:0] core_result_key;
   logic [NUM_CORES-1:0]           core_grant;
   logic [KEY_WIDTH-1:0]           core_key;
   logic                           abort;

   modport master (
      output lfsr_reset, key_read, core_grant, core_key, abort,
      input  key_in, key_available, key_exhausted,
      input  core_req, core_busy, core_found, core_result_key
   );

   modport slave (
      input  lfsr_reset, key_read, core_grant, core_key, abort,
      output key_in, key_available, key_exhausted,
      output core_req, core_busy, core_found, core_result_key
   );
endinterface

// File: rtl/key_dispatcher.sv
// Hands LFSR keys to decryption cores round-robin and collects the winning key.
// Define KEY_DISPATCH_STATS_EN to count grants on keys_issued (else tied to 0).
module key_dispatcher #(
   parameter int NUM_CORES = 4,
   parameter int KEY_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   key_dispatcher_if.master     bus,
   output logic                 done,
   output logic                 success,
   output logic [KEY_WIDTH-1:0] secret_key,
   output logic [KEY_WIDTH:0]   keys_issued
);
   localparam int unsigned NC = NUM_CORES;
   localparam int          IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [2:0] {IDLE, INIT, DISPATCH, ADVANCE, DRAIN, DONE} state_t;

   state_t               state;
   logic [IW-1:0]        rr_next;
   logic [IW-1:0]        grant_idx;
   logic [IW-1:0]        rr_after;
   logic                 grant_ok;
   logic                 any_found;
   logic [KEY_WIDTH-1:0] found_key;
   logic                 start_fire;
   logic                 grant_fire;

   // First requesting core at or after rr_next, wrapping modulo NUM_CORES.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_idx = '0;
      grant_ok  = 1'b0;
      for (int unsigned off = 0; off < NC; off++) begin
         idx = 32'(rr_next) + off;
         if (idx >= NC) idx = idx - NC;
         if (!grant_ok && bus.core_req[IW'(idx)]) begin
            grant_ok  = 1'b1;
            grant_idx = IW'(idx);
         end
      end
   end

   // Scan downwards so the lowest-index asserting core is the one kept.
   always_comb begin
      any_found = 1'b0;
      found_key = '0;
      for (int unsigned i = NC; i > 0; i--) begin
         if (bus.core_found[IW'(i - 1)]) begin
            any_found = 1'b1;
            found_key = bus.core_result_key[(i - 1) * KEY_WIDTH +: KEY_WIDTH];
         end
      end
   end

   assign rr_after   = (32'(grant_idx) == NC - 1) ? '0 : grant_idx + 1'b1;
   assign start_fire = start && (state == IDLE || state == DONE);
   assign grant_fire = (state == DISPATCH) && !any_found && !bus.key_exhausted &&
                       bus.key_available && grant_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bus.lfsr_reset <= 1'b1;
         bus.key_read   <= 1'b0;
         bus.core_grant <= '0;
         bus.core_key   <= '0;
         bus.abort      <= 1'b0;
         done           <= 1'b0;
         success        <= 1'b0;
         secret_key     <= '0;
         rr_next        <= '0;
      end else begin
         bus.key_read   <= 1'b0;
         bus.core_grant <= '0;
         case (state)
            IDLE, DONE: begin
               if (start_fire) begin
                  state          <= INIT;
                  bus.lfsr_reset <= 1'b1;
                  bus.abort      <= 1'b0;
                  done           <= 1'b0;
                  success        <= 1'b0;
                  secret_key     <= '0;
                  rr_next        <= '0;
               end
            end
            INIT: begin
               bus.lfsr_reset <= 1'b0;
               state          <= DISPATCH;
            end
            DISPATCH, ADVANCE, DRAIN: begin
               if (any_found) begin
                  secret_key <= found_key;
                  success    <= 1'b1;
                  bus.abort  <= 1'b1;
                  done       <= 1'b1;
                  state      <= DONE;
               end else if (state == DRAIN) begin
                  if (bus.core_busy == '0) begin
                     done    <= 1'b1;
                     success <= 1'b0;
                     state   <= DONE;
                  end
               end else if (bus.key_exhausted) begin
                  state <= DRAIN;
               end else if (grant_fire) begin
                  bus.core_grant <= NUM_CORES'(1) << grant_idx;
                  bus.key_read   <= 1'b1;
                  bus.core_key   <= bus.key_in;
                  rr_next        <= rr_after;
                  state          <= ADVANCE;
               end else if (state == ADVANCE && !bus.key_available) begin
                  state <= DISPATCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KEY_DISPATCH_STATS_EN
   logic [KEY_WIDTH:0] issued_q;

   always_ff @(posedge clk) begin
      if (reset || start_fire) issued_q <= '0;
      else if (grant_fire && issued_q != '1) issued_q <= issued_q + 1'b1;
   end

   assign keys_issued = issued_q;
`else
   assign keys_issued = '0;
`endif
endmodule

// File: tb/tb_key_dispatcher.sv
// Randomized bench for key_dispatcher: a 16-state LFSR generator and busy cores
// are modelled here, grants are predicted from round-robin order over requests.
module tb_key_dispatcher;
   localparam int NC = 4;
   localparam int KW = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          done;
   logic          success;
   logic [KW-1:0] secret_key;
   logic [KW:0]   keys_issued;

   key_dispatcher_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) bus ();

   key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .done(done), .success(success), .secret_key(secret_key), .keys_issued(keys_issued)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // environment and reference-model state
   logic [3:0]    lf;
   int            gap;
   bit            stopped;
   bit            avail_rose;
   int            rr_m;
   logic [3:0]    req_prev;
   logic [3:0]    key_prev;
   bit            seen [16];
   int            grants;
   int            busy_cnt [NC];
   int            req_mode;
   int            exh_age;
   bit            idle_flag;
   bit            drain_chk;
   logic [KW-1:0] rkeys [NC];

   // de Bruijn-extended LFSR: visits all 16 values, seed 4'hF
   function automatic logic [3:0] lfsr_next(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2] ^ (s[2:0] == 3'b000)};
   endfunction

   function automatic logic [KW:0] exp_issued(input int n);
`ifdef KEY_DISPATCH_STATS_EN
      return (KW+1)'(n);
`else
      return (n == 0) ? '0 : '0;
`endif
   endfunction

   task automatic step();
      @(negedge clk);
      if (exh_age >= 0) exh_age++;
      if (bus.key_read || bus.core_grant != '0) begin
         int e;
         logic [3:0] ev;
         e = -1;
         for (int k = 0; k < NC; k++) begin
            int c;
            c = (rr_m + k) % NC;
            if (e < 0 && req_prev[c]) e = c;
         end
         ev = (e < 0) ? 4'b0 : 4'(1 << e);
         check_val("grant_onehot", 64'(bus.core_grant), 64'(ev));
         check_val("key_read", 64'(bus.key_read), 64'd1);
         check_val("core_key", 64'(bus.core_key), 64'(key_prev));
         check_val("key_fresh", 64'(seen[key_prev]), 64'd0);
         seen[key_prev] = 1'b1;
         grants++;
         if (e >= 0) begin
            rr_m = (e + 1) % NC;
            busy_cnt[e] = $urandom_range(1, 6);
         end
      end
      if (drain_chk && exh_age >= 1) check_val("done_drain", 64'(done), 64'(idle_flag));
      // LFSR generator
      bus.key_exhausted = 1'b0;
      avail_rose = 1'b0;
      if (bus.lfsr_reset) begin
         lf = 4'hF; bus.key_available = 1'b1; stopped = 1'b0; gap = 0;
      end else if (bus.key_read) begin
         lf = lfsr_next(lf);
         bus.key_available = 1'b0;
         if (lf == 4'hF) begin
            bus.key_exhausted = 1'b1; stopped = 1'b1; exh_age = 0;
            busy_cnt[0] = 3;
         end else begin
            gap = $urandom_range(0, 2);
         end
      end else if (!stopped && !bus.key_available) begin
         if (gap == 0) begin bus.key_available = 1'b1; avail_rose = 1'b1; end
         else gap--;
      end
      bus.key_in = KW'(lf);
      // cores
      for (int i = 0; i < NC; i++) begin
         bus.core_busy[i] = (busy_cnt[i] != 0);
         if (busy_cnt[i] > 0) busy_cnt[i]--;
      end
      case (req_mode)
         0:       bus.core_req = 4'hF;
         1:       bus.core_req = 4'($urandom_range(0, 15));
         default: bus.core_req = 4'b0010;
      endcase
      if (exh_age >= 1 && bus.core_busy == '0) idle_flag = 1'b1;
      req_prev = bus.core_req;
      key_prev = lf;
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_lfsr_reset"}, 64'(bus.lfsr_reset), 64'd1);
      check_val({tag, "_key_read"},   64'(bus.key_read),   64'd0);
      check_val({tag, "_core_grant"}, 64'(bus.core_grant), 64'd0);
      check_val({tag, "_core_key"},   64'(bus.core_key),   64'd0);
      check_val({tag, "_abort"},      64'(bus.abort),      64'd0);
      check_val({tag, "_done"},       64'(done),           64'd0);
      check_val({tag, "_success"},    64'(success),        64'd0);
      check_val({tag, "_secret"},     64'(secret_key),     64'd0);
      check_val({tag, "_issued"},     64'(keys_issued),    64'd0);
   endtask

   task automatic run_search(input int mode, input logic [3:0] fmask, input int fafter,
                             input int rst_after, input bit drain);
      bit injected;
      bit pulsed;
      int win;
      req_mode = mode; drain_chk = drain;
      rr_m = 0; grants = 0; exh_age = -1; idle_flag = 1'b0;
      foreach (seen[i]) seen[i] = 1'b0;
      for (int i = 0; i < NC; i++) bus.core_result_key[i*KW +: KW] = rkeys[i];
      injected = 1'b0; pulsed = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("init_lfsr_reset", 64'(bus.lfsr_reset), 64'd1);
      check_val("init_done",       64'(done),           64'd0);
      check_val("init_success",    64'(success),        64'd0);
      check_val("init_abort",      64'(bus.abort),      64'd0);
      check_val("init_secret",     64'(secret_key),     64'd0);
      check_val("init_issued",     64'(keys_issued),    64'd0);
      for (int t = 0; t < 3000; t++) begin
         step();
         if (pulsed) begin start = 1'b0; pulsed = 1'b0; end
         if (injected) begin
            win = 0;
            while (!fmask[win]) win++;
            check_val("found_no_grant", 64'(bus.core_grant), 64'd0);
            check_val("found_no_read",  64'(bus.key_read),   64'd0);
            check_val("found_done",     64'(done),           64'd1);
            check_val("found_success",  64'(success),        64'd1);
            check_val("found_abort",    64'(bus.abort),      64'd1);
            check_val("found_secret",   64'(secret_key),     64'(rkeys[win]));
            check_val("found_issued",   64'(keys_issued),    64'(exp_issued(grants)));
            bus.core_found = '0;
            for (int h = 0; h < 3; h++) step();
            check_val("hold_done",   64'(done),       64'd1);
            check_val("hold_abort",  64'(bus.abort),  64'd1);
            check_val("hold_secret", 64'(secret_key), 64'(rkeys[win]));
            return;
         end
         if (rst_after > 0 && grants == rst_after && bus.key_read) begin
            reset = 1'b1;
            step();
            check_reset_values("midrst");
            reset = 1'b0;
            return;
         end
         if (drain && done) begin
            check_val("drain_success", 64'(success),     64'd0);
            check_val("drain_grants",  64'(grants),      64'd16);
            check_val("drain_issued",  64'(keys_issued), 64'(exp_issued(16)));
            return;
         end
         if (fmask != 0 && grants >= fafter && avail_rose) begin
            bus.core_found = fmask;
            injected = 1'b1;
         end else if (mode == 1 && grants >= 1 && !done && $urandom_range(0, 15) == 0) begin
            start = 1'b1;
            pulsed = 1'b1;
         end
      end
      check_val("timeout", 64'd1, 64'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      bus.key_in = '0; bus.key_available = 1'b0; bus.key_exhausted = 1'b0;
      bus.core_req = '0; bus.core_busy = '0; bus.core_found = '0; bus.core_result_key = '0;
      lf = 4'hF; gap = 0; stopped = 1'b0; avail_rose = 1'b0;
      rr_m = 0; req_prev = '0; key_prev = '0; grants = 0; req_mode = 0;
      exh_age = -1; idle_flag = 1'b0; drain_chk = 1'b0;
      foreach (busy_cnt[i]) busy_cnt[i] = 0;
      foreach (rkeys[i]) rkeys[i] = KW'($urandom);
      repeat (3) step();
      check_reset_values("por");
      reset = 1'b0;
      step();

      // all cores requesting, no match: full key space then drain
      run_search(0, 4'b0000, 0, 0, 1'b1);
      // core 2 finds while core 1 would be granted
      rkeys[2] = 24'h3A5C11;
      run_search(2, 4'b0100, 2, 0, 1'b0);
      // cores 1 and 3 find together, random requests
      foreach (rkeys[i]) rkeys[i] = KW'($urandom);
      run_search(1, 4'b1010, 3, 0, 1'b0);
      // reset while a grant is in flight, then a fresh exhaustive search
      run_search(1, 4'b0000, 0, 5, 1'b0);
      step();
      run_search(1, 4'b0000, 0, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
